// File: rtl/forward_select_stage_pkg.sv
// Shared MIPS pipeline definitions: forwarding-mux selector codes and the
// shadow-slot record that tracks an in-flight instruction's destination.
package mips_pipe_pkg;

  localparam int REG_BITS = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;
  localparam logic [1:0] FWD_LATEWB  = 2'b11;

  localparam logic [REG_BITS-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic [REG_BITS-1:0] write_reg;
  } shadow_slot_t;

  localparam shadow_slot_t SLOT_BUBBLE = '0;

  // A slot can only forward if it really writes a register other than $0.
  function automatic logic slot_match(input shadow_slot_t slot,
                                      input logic [REG_BITS-1:0] reg_idx);
    return slot.reg_write && (slot.write_reg != REG_ZERO) &&
           (slot.write_reg == reg_idx);
  endfunction

endpackage

// File: rtl/forward_select_stage_if.sv
// ID-side controls and EX-side forwarding outputs of the forward/hazard stage.
interface forward_select_stage_if #(
  parameter int NBits   = 32,
  parameter int RegBits = 5
);

  logic [RegBits-1:0] ID_Rs;
  logic [RegBits-1:0] ID_Rt;
  logic               ID_RegWrite;
  logic               ID_MemRead;
  logic [RegBits-1:0] ID_WriteReg;
  logic               Flush;
  logic [NBits-1:0]   WB_WriteData;
  logic               Stall;
  logic [1:0]         EX_ForwardA;
  logic [1:0]         EX_ForwardB;
  logic [NBits-1:0]   LateWB_Data;

  modport master (
    output ID_Rs, ID_Rt, ID_RegWrite, ID_MemRead, ID_WriteReg, Flush, WB_WriteData,
    input  Stall, EX_ForwardA, EX_ForwardB, LateWB_Data
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_RegWrite, ID_MemRead, ID_WriteReg, Flush, WB_WriteData,
    output Stall, EX_ForwardA, EX_ForwardB, LateWB_Data
  );

endinterface

// File: rtl/forward_select_stage_compare.sv
// Priority matcher: picks the youngest in-flight producer of one source
// register and returns the EX operand-mux selector for it.
module forward_compare
  import mips_pipe_pkg::*;
(
  input  logic [REG_BITS-1:0] reg_idx,
  input  shadow_slot_t        slot_ex,
  input  shadow_slot_t        slot_mem,
  input  shadow_slot_t        slot_wb,
  output logic [1:0]          sel
);

  // Producer in the EX slot now sits in MEM once the consumer reaches EX.
  always_comb begin
    sel = FWD_REGFILE;
    if (reg_idx != REG_ZERO) begin
      if (slot_match(slot_ex, reg_idx)) begin
        sel = FWD_EXMEM;
      end else if (slot_match(slot_mem, reg_idx)) begin
        sel = FWD_MEMWB;
      end else if (slot_match(slot_wb, reg_idx)) begin
        sel = FWD_LATEWB;
      end
    end
  end

endmodule

// File: rtl/forward_select_stage.sv
// ID->EX forwarding-select and load-use hazard stage: shadow pipeline of
// destinations, registered operand-mux selectors and the late-writeback buffer.
module forward_select_stage
  import mips_pipe_pkg::*;
#(
  parameter int NBits   = 32,
  parameter int RegBits = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  forward_select_stage_if.slave bus
);

  shadow_slot_t       slot_ex;
  shadow_slot_t       slot_mem;
  shadow_slot_t       slot_wb;
  shadow_slot_t       id_slot;
  logic [RegBits-1:0] id_rs;
  logic [RegBits-1:0] id_rt;
  logic [1:0]         sel_a;
  logic [1:0]         sel_b;
  logic [1:0]         fwd_a_q;
  logic [1:0]         fwd_b_q;
  logic [NBits-1:0]   late_wb_q;
  logic               hazard;
  logic               stall;
  logic               advance;
  logic               late_capture;

  assign id_rs = bus.ID_Rs;
  assign id_rt = bus.ID_Rt;

  assign id_slot = '{reg_write: bus.ID_RegWrite,
                     mem_read:  bus.ID_MemRead,
                     write_reg: bus.ID_WriteReg};

  forward_compare u_cmp_a (
    .reg_idx  (id_rs),
    .slot_ex  (slot_ex),
    .slot_mem (slot_mem),
    .slot_wb  (slot_wb),
    .sel      (sel_a)
  );

  forward_compare u_cmp_b (
    .reg_idx  (id_rt),
    .slot_ex  (slot_ex),
    .slot_mem (slot_mem),
    .slot_wb  (slot_wb),
    .sel      (sel_b)
  );

  // Load data is not ready until after MEM, so a load in EX cannot feed ID.
  assign hazard       = slot_ex.mem_read &
                        (slot_match(slot_ex, id_rs) | slot_match(slot_ex, id_rt));
  assign stall        = hazard & ~bus.Flush;
  assign advance      = ~stall & ~bus.Flush;
  assign late_capture = slot_wb.reg_write & (slot_wb.write_reg != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_ex   <= SLOT_BUBBLE;
      slot_mem  <= SLOT_BUBBLE;
      slot_wb   <= SLOT_BUBBLE;
      fwd_a_q   <= FWD_REGFILE;
      fwd_b_q   <= FWD_REGFILE;
      late_wb_q <= '0;
    end else begin
      slot_wb  <= slot_mem;
      slot_mem <= slot_ex;
      if (advance) begin
        slot_ex <= id_slot;
        fwd_a_q <= sel_a;
        fwd_b_q <= sel_b;
      end else begin
        slot_ex <= SLOT_BUBBLE;
        fwd_a_q <= FWD_REGFILE;
        fwd_b_q <= FWD_REGFILE;
      end
      if (late_capture) begin
        late_wb_q <= bus.WB_WriteData;
      end
    end
  end

  assign bus.Stall       = stall;
  assign bus.EX_ForwardA = fwd_a_q;
  assign bus.EX_ForwardB = fwd_b_q;
  assign bus.LateWB_Data = late_wb_q;

endmodule

// File: tb/tb_forward_select_stage.sv
// Randomized and directed bench for forward_select_stage against a list-based
// model of the three most recently issued instructions.
module tb_forward_select_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  forward_select_stage_if #(.NBits(32), .RegBits(5)) bus ();

  forward_select_stage #(.NBits(32), .RegBits(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issued instructions, youngest first; a bubble never writes.
  typedef struct {
    bit rw;
    bit mr;
    int wr;
  } instr_t;

  instr_t      inflight[3];
  bit [1:0]    m_fa;
  bit [1:0]    m_fb;
  logic [31:0] m_late;

  function automatic bit writes(input instr_t i, input int r);
    return i.rw && (i.wr != 0) && (i.wr == r);
  endfunction

  // Distance to the youngest producer decides the mux input: 1 -> 01, 2 -> 10, 3 -> 11.
  function automatic bit [1:0] m_sel(input int r);
    if (r == 0) return 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (writes(inflight[k], r)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) inflight[k] = '{1'b0, 1'b0, 0};
    m_fa   = 2'd0;
    m_fb   = 2'd0;
    m_late = 32'd0;
  endtask

  // Called at a negedge; drives ID for one cycle and checks stall and the
  // registered outputs that result.
  task automatic cycle(input int rs, input int rt, input bit rw, input bit mr,
                       input int wr, input bit fl, input logic [31:0] wd,
                       input int exp_stall);
    bit       hz;
    bit       st;
    bit [1:0] na;
    bit [1:0] nb;
    bus.ID_Rs        = 5'(rs);
    bus.ID_Rt        = 5'(rt);
    bus.ID_RegWrite  = rw;
    bus.ID_MemRead   = mr;
    bus.ID_WriteReg  = 5'(wr);
    bus.Flush        = fl;
    bus.WB_WriteData = wd;
    #1;
    hz = inflight[0].mr && (writes(inflight[0], rs) || writes(inflight[0], rt));
    st = hz && !fl;
    check("stall", 32'(bus.Stall), 32'(st));
    if (exp_stall >= 0) check("stall_directed", 32'(bus.Stall), 32'(exp_stall));
    na = m_sel(rs);
    nb = m_sel(rt);
    @(posedge clk);
    if (inflight[2].rw && inflight[2].wr != 0) m_late = wd;
    inflight[2] = inflight[1];
    inflight[1] = inflight[0];
    if (!st && !fl) begin
      inflight[0] = '{rw, mr, wr};
      m_fa = na;
      m_fb = nb;
    end else begin
      inflight[0] = '{1'b0, 1'b0, 0};
      m_fa = 2'd0;
      m_fb = 2'd0;
    end
    @(negedge clk);
    check("fwd_a", 32'(bus.EX_ForwardA), 32'(m_fa));
    check("fwd_b", 32'(bus.EX_ForwardB), 32'(m_fb));
    check("late_wb", bus.LateWB_Data, m_late);
  endtask

  task automatic idle(input logic [31:0] wd);
    cycle(0, 0, 1'b0, 1'b0, 0, 1'b0, wd, -1);
  endtask

  initial begin
    model_reset();
    reset            = 1'b1;
    bus.ID_Rs        = 5'd3;
    bus.ID_Rt        = 5'd3;
    bus.ID_RegWrite  = 1'b1;
    bus.ID_MemRead   = 1'b1;
    bus.ID_WriteReg  = 5'd3;
    bus.Flush        = 1'b0;
    bus.WB_WriteData = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(bus.Stall), 32'd0);
    check("rst_fwd_a", 32'(bus.EX_ForwardA), 32'd0);
    check("rst_fwd_b", 32'(bus.EX_ForwardB), 32'd0);
    check("rst_late", bus.LateWB_Data, 32'd0);
    reset = 1'b0;
    idle(32'd0);
    idle(32'd0);
    check("idle_fwd_a", 32'(bus.EX_ForwardA), 32'd0);
    check("idle_fwd_b", 32'(bus.EX_ForwardB), 32'd0);

    // add $5 ; sub uses $5
    cycle(1, 2, 1'b1, 1'b0, 5, 1'b0, 32'd0, -1);
    cycle(5, 6, 1'b1, 1'b0, 7, 1'b0, 32'd0, 0);
    check("alu_fwd_exmem", 32'(bus.EX_ForwardA), 32'd1);
    idle(32'd0); idle(32'd0); idle(32'd0);

    // add $5 ; independent ; consumer
    cycle(1, 2, 1'b1, 1'b0, 5, 1'b0, 32'd0, -1);
    cycle(1, 2, 1'b1, 1'b0, 9, 1'b0, 32'd0, -1);
    cycle(5, 0, 1'b0, 1'b0, 0, 1'b0, 32'd0, -1);
    check("alu_fwd_memwb", 32'(bus.EX_ForwardA), 32'd2);
    idle(32'd0); idle(32'd0); idle(32'd0);

    // add $5 ; two independent ; consumer while add writes back 0xDEADBEEF
    cycle(1, 2, 1'b1, 1'b0, 5, 1'b0, 32'd0, -1);
    cycle(1, 2, 1'b1, 1'b0, 9, 1'b0, 32'd0, -1);
    cycle(1, 2, 1'b1, 1'b0, 10, 1'b0, 32'd0, -1);
    cycle(5, 0, 1'b0, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, -1);
    check("alu_fwd_late", 32'(bus.EX_ForwardA), 32'd3);
    check("late_value", bus.LateWB_Data, 32'hDEAD_BEEF);
    idle(32'd0); idle(32'd0); idle(32'd0);

    // lw $8 ; add uses Rt=8 (stalls once, then resolves to MEM/WB)
    cycle(1, 2, 1'b1, 1'b1, 8, 1'b0, 32'd0, -1);
    cycle(3, 8, 1'b1, 1'b0, 11, 1'b0, 32'd0, 1);
    check("load_bubble_b", 32'(bus.EX_ForwardB), 32'd0);
    cycle(3, 8, 1'b1, 1'b0, 11, 1'b0, 32'd0, 0);
    check("load_use_b", 32'(bus.EX_ForwardB), 32'd2);
    idle(32'd0); idle(32'd0); idle(32'd0);

    // add $4 ; or $4 ; and uses $4 -> youngest producer
    cycle(1, 2, 1'b1, 1'b0, 4, 1'b0, 32'd0, -1);
    cycle(1, 2, 1'b1, 1'b0, 4, 1'b0, 32'd0, -1);
    cycle(4, 0, 1'b1, 1'b0, 12, 1'b0, 32'd0, -1);
    check("youngest_wins", 32'(bus.EX_ForwardA), 32'd1);
    cycle(1, 2, 1'b1, 1'b0, 0, 1'b0, 32'd0, -1);
    cycle(0, 0, 1'b1, 1'b0, 13, 1'b0, 32'd0, -1);
    check("reg_zero_a", 32'(bus.EX_ForwardA), 32'd0);
    idle(32'd0); idle(32'd0); idle(32'd0);

    // lw $2 ; wrong-path consumer is flushed instead of stalling
    cycle(1, 3, 1'b1, 1'b1, 2, 1'b0, 32'd0, -1);
    cycle(2, 2, 1'b1, 1'b0, 14, 1'b1, 32'd0, 0);
    check("flush_fwd_a", 32'(bus.EX_ForwardA), 32'd0);
    check("flush_fwd_b", 32'(bus.EX_ForwardB), 32'd0);
    idle(32'd0); idle(32'd0); idle(32'd0);

    for (int n = 0; n < 400; n++) begin
      int rw_roll;
      rw_roll = int'($urandom_range(0, 3));
      cycle(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            rw_roll != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom, -1);
    end

    // Make sure the late buffer holds a non-zero value before the reset pulse.
    cycle(1, 2, 1'b1, 1'b0, 5, 1'b0, 32'd0, -1);
    idle(32'd0);
    idle(32'd0);
    idle(32'hCAFE_F00D);
    check("late_before_reset", bus.LateWB_Data, 32'hCAFE_F00D);

    // lw $6 ; consumer stalls ; async reset pulse between edges
    cycle(1, 2, 1'b1, 1'b1, 6, 1'b0, 32'd0, -1);
    cycle(1, 2, 1'b1, 1'b0, 7, 1'b0, 32'd0, -1);
    check("pre_reset_fwd_a", 32'(bus.EX_ForwardA), 32'd0);
    cycle(1, 2, 1'b1, 1'b1, 6, 1'b0, 32'd0, -1);
    bus.ID_Rs       = 5'd6;
    bus.ID_Rt       = 5'd1;
    bus.ID_RegWrite = 1'b1;
    bus.ID_MemRead  = 1'b0;
    bus.ID_WriteReg = 5'd9;
    bus.Flush       = 1'b0;
    #1;
    check("mid_stall_set", 32'(bus.Stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(bus.Stall), 32'd0);
    check("mid_rst_fwd_a", 32'(bus.EX_ForwardA), 32'd0);
    check("mid_rst_fwd_b", 32'(bus.EX_ForwardB), 32'd0);
    check("mid_rst_late", bus.LateWB_Data, 32'd0);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    cycle(6, 1, 1'b1, 1'b0, 9, 1'b0, 32'd0, 0);
    idle(32'd0);
    idle(32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
